sdf_butterfly_pair: RTL and testbench

//  Radix-2 DIF butterfly stage fed by a span-2^(LAYER-1) delay line and the direct input stream.

---
 rtl/sdf_butterfly_pair.sv | 197 +++++++++++++++++++
 tb/tb_sdf_butterfly_pair.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_butterfly_pair.sv
// Radix-2 DIF butterfly for one SDF FFT layer: pairs delayed/direct samples, emits
// top=(A+B)>>>SCALE and bot=((A-B)>>>SCALE)*W^k over a fixed 3-cycle pipeline.
module sdf_butterfly_pair #(
  parameter int DATA_W   = 32,
  parameter int TW_W     = 16,
  parameter int LAYER    = 11,
  parameter int FFT_LOG2 = 11,
  parameter int SCALE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic [DATA_W-1:0]     din_a_re,
  input  logic [DATA_W-1:0]     din_a_im,
  input  logic [DATA_W-1:0]     din_b_re,
  input  logic [DATA_W-1:0]     din_b_im,
  output logic [FFT_LOG2-2:0]   tw_addr,
  input  logic [TW_W-1:0]       tw_re,
  input  logic [TW_W-1:0]       tw_im,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  output logic [DATA_W-1:0]     top_re,
  output logic [DATA_W-1:0]     top_im,
  output logic [DATA_W-1:0]     bot_re,
  output logic [DATA_W-1:0]     bot_im,
  output logic                  err_overlap
);

  localparam int HALF  = 1 << (LAYER - 1);
  localparam int K_W   = (LAYER > 1) ? LAYER - 1 : 1;
  localparam int AW    = FFT_LOG2 - 1;
  localparam int SHIFT = FFT_LOG2 - LAYER;
  localparam int SW    = DATA_W + 1;          // sum/diff width
  localparam int PRW   = SW + TW_W;           // single product width
  localparam int PW    = PRW + 1;             // product sum/difference width

  localparam logic [K_W-1:0]       K_LAST = K_W'(HALF - 1);
  localparam logic signed [PW-1:0] RND    = PW'(1) <<< (TW_W - 3);
  localparam logic signed [PW-1:0] MAX_V  = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V  = ~MAX_V;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAX_V)      sat = MAX_V[DATA_W-1:0];
    else if (v < MIN_V) sat = MIN_V[DATA_W-1:0];
    else                sat = v[DATA_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               err_q, err_d;

  logic               s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [SW-1:0] s1_sum_re_q, s1_sum_re_d, s1_sum_im_q, s1_sum_im_d;
  logic signed [SW-1:0] s1_dif_re_q, s1_dif_re_d, s1_dif_im_q, s1_dif_im_d;

  logic               s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [SW-1:0]  s2_sum_re_q, s2_sum_re_d, s2_sum_im_q, s2_sum_im_d;
  logic signed [PRW-1:0] s2_p_rr_q, s2_p_rr_d, s2_p_ii_q, s2_p_ii_d;
  logic signed [PRW-1:0] s2_p_ri_q, s2_p_ri_d, s2_p_ir_q, s2_p_ir_d;

  logic               o_vld_q, o_vld_d, o_first_q, o_first_d, o_last_q, o_last_d;
  logic [DATA_W-1:0]  o_top_re_q, o_top_re_d, o_top_im_q, o_top_im_d;
  logic [DATA_W-1:0]  o_bot_re_q, o_bot_re_d, o_bot_im_q, o_bot_im_d;

  logic               start, accept, is_last;
  logic [K_W-1:0]     k_cur;
  logic signed [PW-1:0] re_w, im_w;

  // Control: frame FSM, pair counter, twiddle address.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    start   = in_valid & in_first;
    accept  = in_valid & (in_first | (state_q == RUN));
    k_cur   = '0;
    if (!start && state_q == RUN) k_cur = k_q;
    is_last = (k_cur == K_LAST);
    state_d = state_q;
    k_d     = k_q;
    if (accept) begin
      if (is_last) begin
        state_d = IDLE;
        k_d     = '0;
      end else begin
        state_d = RUN;
        k_d     = k_cur + K_W'(1);
      end
    end
    // A restart inside a running frame is legal but flagged until reset.
    err_d   = err_q | (start & (state_q == RUN));
    tw_addr = AW'(k_cur) << SHIFT;
  end

  // Datapath: S1 add/sub, S2 complex products (ROM data arrives here), S3 round/saturate.
  always_comb begin
    s1_vld_d    = accept;
    s1_first_d  = accept & (k_cur == '0);
    s1_last_d   = accept & is_last;
    s1_sum_re_d = (SW'($signed(din_a_re)) + SW'($signed(din_b_re))) >>> SCALE;
    s1_sum_im_d = (SW'($signed(din_a_im)) + SW'($signed(din_b_im))) >>> SCALE;
    s1_dif_re_d = (SW'($signed(din_a_re)) - SW'($signed(din_b_re))) >>> SCALE;
    s1_dif_im_d = (SW'($signed(din_a_im)) - SW'($signed(din_b_im))) >>> SCALE;

    s2_vld_d    = s1_vld_q;
    s2_first_d  = s1_first_q;
    s2_last_d   = s1_last_q;
    s2_sum_re_d = s1_sum_re_q;
    s2_sum_im_d = s1_sum_im_q;
    s2_p_rr_d   = PRW'(s1_dif_re_q) * PRW'($signed(tw_re));
    s2_p_ii_d   = PRW'(s1_dif_im_q) * PRW'($signed(tw_im));
    s2_p_ri_d   = PRW'(s1_dif_re_q) * PRW'($signed(tw_im));
    s2_p_ir_d   = PRW'(s1_dif_im_q) * PRW'($signed(tw_re));

    re_w        = (PW'(s2_p_rr_q) - PW'(s2_p_ii_q) + RND) >>> (TW_W - 2);
    im_w        = (PW'(s2_p_ri_q) + PW'(s2_p_ir_q) + RND) >>> (TW_W - 2);
    o_vld_d     = s2_vld_q;
    o_first_d   = s2_first_q;
    o_last_d    = s2_last_q;
    o_top_re_d  = sat(PW'(s2_sum_re_q));
    o_top_im_d  = sat(PW'(s2_sum_im_q));
    o_bot_re_d  = sat(re_w);
    o_bot_im_d  = sat(im_w);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  // NOTE: data registers are reset too, because the outputs must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      err_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_re_q <= '0;
      s1_sum_im_q <= '0;
      s1_dif_re_q <= '0;
      s1_dif_im_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_re_q <= '0;
      s2_sum_im_q <= '0;
      s2_p_rr_q   <= '0;
      s2_p_ii_q   <= '0;
      s2_p_ri_q   <= '0;
      s2_p_ir_q   <= '0;
      o_vld_q     <= 1'b0;
      o_first_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o_top_re_q  <= '0;
      o_top_im_q  <= '0;
      o_bot_re_q  <= '0;
      o_bot_im_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      err_q       <= err_d;
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_sum_re_q <= s1_sum_re_d;
      s1_sum_im_q <= s1_sum_im_d;
      s1_dif_re_q <= s1_dif_re_d;
      s1_dif_im_q <= s1_dif_im_d;
      s2_vld_q    <= s2_vld_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_sum_re_q <= s2_sum_re_d;
      s2_sum_im_q <= s2_sum_im_d;
      s2_p_rr_q   <= s2_p_rr_d;
      s2_p_ii_q   <= s2_p_ii_d;
      s2_p_ri_q   <= s2_p_ri_d;
      s2_p_ir_q   <= s2_p_ir_d;
      o_vld_q     <= o_vld_d;
      o_first_q   <= o_first_d;
      o_last_q    <= o_last_d;
      o_top_re_q  <= o_top_re_d;
      o_top_im_q  <= o_top_im_d;
      o_bot_re_q  <= o_bot_re_d;
      o_bot_im_q  <= o_bot_im_d;
    end
  end

  assign out_valid   = o_vld_q;
  assign out_first   = o_first_q;
  assign out_last    = o_last_q;
  assign top_re      = o_top_re_q;
  assign top_im      = o_top_im_q;
  assign bot_re      = o_bot_re_q;
  assign bot_im      = o_bot_im_q;
  assign err_overlap = err_q;

endmodule

// File: tb/tb_sdf_butterfly_pair.sv
// Directed bench: single-pair frames (HALF=1) for arithmetic, LAYER=3 instance for framing.
module tb_sdf_butterfly_pair;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_first;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic [15:0] tw_drv_re, tw_drv_im, tw_re, tw_im;

  logic [0:0]  tw_addr0, tw_addr1;
  logic [2:0]  tw_addr2;
  logic        o0_valid, o0_first, o0_last, o0_err;
  logic        o1_valid, o1_first, o1_last, o1_err;
  logic        o2_valid, o2_first, o2_last, o2_err;
  logic [31:0] o0_top_re, o0_top_im, o0_bot_re, o0_bot_im;
  logic [31:0] o1_top_re, o1_top_im, o1_bot_re, o1_bot_im;
  logic [31:0] o2_top_re, o2_top_im, o2_bot_re, o2_bot_im;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External twiddle ROM: one-cycle registered read of whatever the bench selects.
  always_ff @(posedge clk) begin
    tw_re <= tw_drv_re;
    tw_im <= tw_drv_im;
  end

  sdf_butterfly_pair #(.DATA_W(32), .TW_W(16), .LAYER(1), .FFT_LOG2(2), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .din_a_re(a_re), .din_a_im(a_im), .din_b_re(b_re), .din_b_im(b_im),
    .tw_addr(tw_addr0), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(o0_valid), .out_first(o0_first), .out_last(o0_last),
    .top_re(o0_top_re), .top_im(o0_top_im), .bot_re(o0_bot_re), .bot_im(o0_bot_im),
    .err_overlap(o0_err));

  sdf_butterfly_pair #(.DATA_W(32), .TW_W(16), .LAYER(1), .FFT_LOG2(2), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .din_a_re(a_re), .din_a_im(a_im), .din_b_re(b_re), .din_b_im(b_im),
    .tw_addr(tw_addr1), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(o1_valid), .out_first(o1_first), .out_last(o1_last),
    .top_re(o1_top_re), .top_im(o1_top_im), .bot_re(o1_bot_re), .bot_im(o1_bot_im),
    .err_overlap(o1_err));

  sdf_butterfly_pair #(.DATA_W(32), .TW_W(16), .LAYER(3), .FFT_LOG2(4), .SCALE(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .din_a_re(a_re), .din_a_im(a_im), .din_b_re(b_re), .din_b_im(b_im),
    .tw_addr(tw_addr2), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(o2_valid), .out_first(o2_first), .out_last(o2_last),
    .top_re(o2_top_re), .top_im(o2_top_im), .bot_re(o2_bot_re), .bot_im(o2_bot_im),
    .err_overlap(o2_err));

  typedef struct {
    logic        scl;
    logic [31:0] a_re, a_im, b_re, b_im;
    logic [15:0] w_re, w_im;
    logic [31:0] top_re, top_im, bot_re, bot_im;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic f);
    in_valid = v;
    in_first = f;
    a_re = 32'd100; a_im = 32'd0; b_re = 32'd20; b_im = 32'd0;
    tw_drv_re = 16'd16384; tw_drv_im = 16'd0;
  endtask

  initial begin
    // Expected values hand-derived: diff*W, +8192, >>>14 (floor), then saturate.
    vecs[0]  = '{1'b0, 32'd100, 32'd0, 32'd20, 32'd0, 16'd16384, 16'd0,
                 32'd120, 32'd0, 32'd80, 32'd0};
    vecs[1]  = '{1'b0, 32'd100, 32'd0, 32'd20, 32'd0, 16'd0, -16'sd16384,
                 32'd120, 32'd0, 32'd0, -32'sd80};
    vecs[2]  = '{1'b1, 32'd100, 32'd0, 32'd20, 32'd0, 16'd0, -16'sd16384,
                 32'd60, 32'd0, 32'd0, -32'sd40};
    vecs[3]  = '{1'b0, 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0, 16'd16384, 16'd0,
                 32'h7FFFFFFF, 32'd0, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 32'h7FFFFFFF, 32'd0, 32'h80000000, 32'd0, 16'd16384, 16'd0,
                 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd0};
    vecs[5]  = '{1'b0, 32'h80000000, 32'd0, 32'h80000000, 32'd0, 16'd16384, 16'd0,
                 32'h80000000, 32'd0, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 32'd1000, -32'sd500, 32'd200, 32'd300, 16'd11585, 16'd11585,
                 32'd1200, -32'sd200, 32'd1131, 32'd0};
    vecs[7]  = '{1'b1, 32'd7, -32'sd7, 32'd0, 32'd0, 16'd16384, 16'd0,
                 32'd3, -32'sd4, 32'd3, -32'sd4};
    vecs[8]  = '{1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 16'd8192, 16'd0,
                 32'd1, 32'd0, 32'd1, 32'd0};
    vecs[9]  = '{1'b0, -32'sd1, 32'd0, 32'd0, 32'd0, 16'd8192, 16'd0,
                 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'd0, 32'h80000000, 32'd0, -16'sd16384, 16'd0,
                 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0};
    vecs[11] = '{1'b0, 32'd0, 32'd100, 32'd0, 32'd0, 16'd0, 16'd16384,
                 32'd0, 32'd100, -32'sd100, 32'd0};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    tw_drv_re = '0; tw_drv_im = '0;

    // Reset held two cycles: everything reads zero.
    repeat (2) @(negedge clk);
    check("rst_valid", o0_valid, 1'b0);
    check("rst_first", o0_first, 1'b0);
    check("rst_last", o0_last, 1'b0);
    check("rst_top_re", o0_top_re, 32'd0);
    check("rst_bot_im", o0_bot_im, 32'd0);
    check("rst_err", o0_err, 1'b0);
    check("rst_tw_addr", tw_addr2, 3'd0);
    check("rst_valid2", o2_valid, 1'b0);
    rst = 1'b0;

    // Arithmetic vectors, each a one-pair frame on the HALF=1 instances.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_first = 1'b1;
      a_re = vecs[i].a_re; a_im = vecs[i].a_im;
      b_re = vecs[i].b_re; b_im = vecs[i].b_im;
      tw_drv_re = vecs[i].w_re; tw_drv_im = vecs[i].w_im;
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0;
      repeat (2) @(negedge clk);
      if (vecs[i].scl) begin
        check($sformatf("v%0d_valid", i), o1_valid, 1'b1);
        check($sformatf("v%0d_first_last", i), {o1_first, o1_last}, 2'b11);
        check($sformatf("v%0d_top_re", i), o1_top_re, vecs[i].top_re);
        check($sformatf("v%0d_top_im", i), o1_top_im, vecs[i].top_im);
        check($sformatf("v%0d_bot_re", i), o1_bot_re, vecs[i].bot_re);
        check($sformatf("v%0d_bot_im", i), o1_bot_im, vecs[i].bot_im);
      end else begin
        check($sformatf("v%0d_valid", i), o0_valid, 1'b1);
        check($sformatf("v%0d_first_last", i), {o0_first, o0_last}, 2'b11);
        check($sformatf("v%0d_top_re", i), o0_top_re, vecs[i].top_re);
        check($sformatf("v%0d_top_im", i), o0_top_im, vecs[i].top_im);
        check($sformatf("v%0d_bot_re", i), o0_bot_re, vecs[i].bot_re);
        check($sformatf("v%0d_bot_im", i), o0_bot_im, vecs[i].bot_im);
      end
      @(negedge clk);
      check($sformatf("v%0d_bubble", i), o0_valid, 1'b0);
    end
    check("half1_no_err", o0_err, 1'b0);

    // LAYER=3: four pairs with 2-cycle gaps, addresses 0,2,4,6, out_last on the 4th.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      logic ev;
      @(negedge clk);
      ev = (t >= 3) && ((t - 3) % 3 == 0) && ((t - 3) / 3 < 4);
      check($sformatf("f_t%0d_valid", t), o2_valid, ev);
      check($sformatf("f_t%0d_first", t), o2_first, ev && (t == 3));
      check($sformatf("f_t%0d_last", t), o2_last, ev && (t == 12));
      if ((t % 3 == 0) && (t / 3 < 4)) begin
        drive(1'b1, t == 0);
        #1 check($sformatf("f_t%0d_tw_addr", t), tw_addr2, 32'(2 * (t / 3)));
      end else begin
        drive(1'b0, 1'b0);
      end
    end
    check("f_top_re", o2_top_re, 32'd120);
    check("f_no_err", o2_err, 1'b0);
    // Back in IDLE: a pair without in_first is dropped.
    @(negedge clk);
    drive(1'b1, 1'b0);
    #1 check("idle_drop_tw_addr", tw_addr2, 3'd0);
    @(negedge clk);
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_drop_valid", o2_valid, 1'b0);

    // Reset after the second pair flushes the pipeline.
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0);
    #1 check("mid_rst_tw2", tw_addr2, 3'd2);
    @(negedge clk);
    drive(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", o2_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_b", o2_valid, 1'b0);
    drive(1'b1, 1'b1);
    #1 check("mid_rst_new_tw0", tw_addr2, 3'd0);
    check("mid_rst_err", o2_err, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0);
    #1 check("mid_rst_new_tw2", tw_addr2, 3'd2);
    @(negedge clk);
    drive(1'b0, 1'b0);

    // in_first on the third pair restarts the frame and sets the sticky error.
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1);
    #1 check("ovl_restart_tw0", tw_addr2, 3'd0);
    check("ovl_err_before", o2_err, 1'b0);
    @(negedge clk);
    check("ovl_out0_first", {o2_valid, o2_first}, 2'b11);
    drive(1'b1, 1'b0);
    #1 check("ovl_next_tw2", tw_addr2, 3'd2);
    check("ovl_err_set", o2_err, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0);
    check("ovl_out1", {o2_valid, o2_first}, 2'b10);
    @(negedge clk);
    check("ovl_out2_first", {o2_valid, o2_first}, 2'b11);
    repeat (4) @(negedge clk);
    check("ovl_err_sticky", o2_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
